// File: rtl/solution_unpacker.sv
// solution_unpacker: rebuilds the board dimensions and the row-major
// solution bitmap from the serialized frame m, n, body bytes.
// Body bits are packed LSB-first; cell index 8*j+b sits in body byte j, bit b.
// Decoding happens in a shadow register. The visible outputs change only
// when a complete, well-formed frame has been received.
module solution_unpacker #(
    parameter int MAX_ROWS       = 11,
    parameter int MAX_COLS       = 11,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                                clk_50mhz,
    input  logic                                rst,
    input  logic [7:0]                          byte_in,
    input  logic                                valid_in,
    output logic [MAX_ROWS*MAX_COLS-1:0]        solution,
    output logic [$clog2(MAX_ROWS)-1:0]         m,
    output logic [$clog2(MAX_COLS)-1:0]         n,
    output logic                                done,
    output logic                                error,
    output logic                                busy
);

    localparam int BITS   = MAX_ROWS * MAX_COLS;
    localparam int M_W    = $clog2(MAX_ROWS);
    localparam int N_W    = $clog2(MAX_COLS);
    localparam int TOT_W  = $clog2(BITS + 1);
    localparam int K_W    = TOT_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        HDR_M = 2'd0,
        HDR_N = 2'd1,
        BODY  = 2'd2
    } state_t;

    state_t               state_r;
    logic [M_W-1:0]       m_shadow_r;
    logic [N_W-1:0]       n_shadow_r;
    logic [TOT_W-1:0]     total_r;
    logic [K_W-1:0]       k_r;
    logic [IDLE_W-1:0]    idle_r;
    logic [BITS-1:0]      shadow_r;

    logic [TOT_W-1:0]     prod_s;
    logic [BITS-1:0]      tot_mask_s;
    logic [BITS-1:0]      ins_mask_s;
    logic [BITS-1:0]      byte_vec_s;
    logic [BITS-1:0]      shadow_next_s;
    logic                 final_s;
    logic                 m_ok_s;
    logic                 n_ok_s;
    logic                 timeout_s;

    // A header byte is legal when it lies in 1..limit.
    function automatic logic in_range(input logic [7:0] value, input logic [7:0] limit);
        in_range = (value >= 8'd1) && (value <= limit);
    endfunction

    // Header validation, cell count, and the 8-bit insert at offset k into the shadow bitmap.
    always_comb begin
        m_ok_s        = in_range(byte_in, 8'(MAX_ROWS));
        n_ok_s        = in_range(byte_in, 8'(MAX_COLS));
        prod_s        = TOT_W'(m_shadow_r) * TOT_W'(byte_in[N_W-1:0]);
        // Cells at index >= total are never written, so bits past m*n stay 0.
        tot_mask_s    = ~({BITS{1'b1}} << total_r);
        ins_mask_s    = ({{(BITS-8){1'b0}}, 8'hFF} << k_r) & tot_mask_s;
        byte_vec_s    = {{(BITS-8){1'b0}}, byte_in} << k_r;
        shadow_next_s = (shadow_r & ~ins_mask_s) | (byte_vec_s & ins_mask_s);
        final_s       = (k_r + K_W'(8)) >= {1'b0, total_r};
        // A byte arriving on the last allowed idle cycle still wins over the timeout.
        timeout_s     = (idle_r == IDLE_LAST) && !valid_in;
    end

    // Frame FSM: header checks, body decode, commit, timeout, and registered outputs.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_r    <= HDR_M;
            m_shadow_r <= '0;
            n_shadow_r <= '0;
            total_r    <= '0;
            k_r        <= '0;
            idle_r     <= '0;
            shadow_r   <= '0;
            solution   <= '0;
            m          <= '0;
            n          <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state_r)
                HDR_M: begin
                    idle_r <= '0;
                    if (valid_in) begin
                        if (m_ok_s) begin
                            m_shadow_r <= byte_in[M_W-1:0];
                            shadow_r   <= '0;
                            busy       <= 1'b1;
                            state_r    <= HDR_N;
                        end else begin
                            error <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                HDR_N: begin
                    if (valid_in) begin
                        idle_r <= '0;
                        if (n_ok_s) begin
                            n_shadow_r <= byte_in[N_W-1:0];
                            total_r    <= prod_s;
                            k_r        <= '0;
                            state_r    <= BODY;
                        end else begin
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= HDR_M;
                        end
                    end else if (timeout_s) begin
                        idle_r  <= '0;
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= HDR_M;
                    end else begin
                        idle_r <= idle_r + IDLE_W'(1);
                    end
                end
                BODY: begin
                    if (valid_in) begin
                        idle_r   <= '0;
                        shadow_r <= shadow_next_s;
                        if (final_s) begin
                            solution <= shadow_next_s;
                            m        <= m_shadow_r;
                            n        <= n_shadow_r;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state_r  <= HDR_M;
                        end else begin
                            k_r <= k_r + K_W'(8);
                        end
                    end else if (timeout_s) begin
                        idle_r  <= '0;
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= HDR_M;
                    end else begin
                        idle_r <= idle_r + IDLE_W'(1);
                    end
                end
                default: begin
                    idle_r  <= '0;
                    busy    <= 1'b0;
                    state_r <= HDR_M;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_solution_unpacker.sv
// Self-checking bench for solution_unpacker: directed frames from the test
// plan followed by randomized good, bad-header and timeout frames. The
// expected bitmap is rebuilt from the body bytes by plain index arithmetic.
module tb_solution_unpacker;

    localparam int TO = 40;

    logic         clk_50mhz = 1'b0;
    logic         rst       = 1'b1;
    logic [7:0]   byte_in   = 8'd0;
    logic         valid_in  = 1'b0;
    logic [120:0] solution;
    logic [3:0]   m;
    logic [3:0]   n;
    logic         done;
    logic         error;
    logic         busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [120:0] exp_sol = '0;
    int           exp_m   = 0;
    int           exp_n   = 0;
    logic [7:0]   body [16];

    solution_unpacker #(
        .MAX_ROWS(11),
        .MAX_COLS(11),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .rst(rst),
        .byte_in(byte_in),
        .valid_in(valid_in),
        .solution(solution),
        .m(m),
        .n(n),
        .done(done),
        .error(error),
        .busy(busy)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " solution"}, {7'd0, solution}, {7'd0, exp_sol});
        check({tag, " m"}, 128'(m), 128'(exp_m));
        check({tag, " n"}, 128'(n), 128'(exp_n));
    endtask

    // Called at a negedge; returns at the negedge after the capturing posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        valid_in = 1'b0;
        repeat (gap) @(negedge clk_50mhz);
        byte_in  = b;
        valid_in = 1'b1;
        @(negedge clk_50mhz);
        valid_in = 1'b0;
    endtask

    task automatic expect_flags(input string tag, input logic d, input logic e, input logic b);
        check({tag, " done"}, 128'(done), 128'(d));
        check({tag, " error"}, 128'(error), 128'(e));
        check({tag, " busy"}, 128'(busy), 128'(b));
    endtask

    // Sends a full good frame using body[] and updates the expected outputs.
    task automatic run_good(input int mm, input int nn, input int maxgap, input bit idle_after);
        int total;
        int nb;
        total = mm * nn;
        nb    = (total + 7) / 8;
        send_byte(8'(mm), $urandom_range(0, maxgap));
        expect_flags("good m", 1'b0, 1'b0, 1'b1);
        send_byte(8'(nn), $urandom_range(0, maxgap));
        expect_flags("good n", 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < nb; j++) begin
            send_byte(body[j], (maxgap == TO - 1 && j == 0) ? TO - 1 : $urandom_range(0, maxgap));
            if (j < nb - 1) expect_flags("good body", 1'b0, 1'b0, 1'b1);
        end
        exp_sol = '0;
        for (int idx = 0; idx < total; idx++) exp_sol[idx] = body[idx / 8][idx % 8];
        exp_m = mm;
        exp_n = nn;
        expect_flags("good commit", 1'b1, 1'b0, 1'b0);
        check_outputs("good commit");
        if (idle_after) begin
            @(negedge clk_50mhz);
            check("done one cycle", 128'(done), 128'(0));
        end
    endtask

    task automatic run_bad_m(input logic [7:0] v);
        send_byte(v, $urandom_range(0, 3));
        expect_flags("bad m", 1'b0, 1'b1, 1'b0);
        check_outputs("bad m");
        @(negedge clk_50mhz);
        check("bad m error one cycle", 128'(error), 128'(0));
    endtask

    task automatic run_bad_n(input int mm, input logic [7:0] v);
        send_byte(8'(mm), $urandom_range(0, 3));
        expect_flags("bad n hdr", 1'b0, 1'b0, 1'b1);
        send_byte(v, $urandom_range(0, 3));
        expect_flags("bad n", 1'b0, 1'b1, 1'b0);
        check_outputs("bad n");
    endtask

    // Sends m, n and nb body bytes (fewer than needed), then stays silent.
    task automatic run_timeout(input int mm, input int nn, input int nb);
        int early;
        send_byte(8'(mm), 0);
        send_byte(8'(nn), 0);
        for (int j = 0; j < nb; j++) send_byte(8'($urandom_range(0, 255)), 0);
        early = 0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk_50mhz);
            if (i < TO && (error || done || !busy)) early++;
        end
        check("timeout early", 128'(early), 128'(0));
        expect_flags("timeout", 1'b0, 1'b1, 1'b0);
        check_outputs("timeout");
    endtask

    initial begin
        int kind;
        int mm;
        int nn;
        rst = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        rst = 1'b0;
        expect_flags("reset", 1'b0, 1'b0, 1'b0);
        check_outputs("reset");

        // 2x3 frame
        body[0] = 8'h2D;
        run_good(2, 3, 0, 1'b1);
        check("2x3 low bits", 128'(solution[5:0]), 128'(6'b101101));

        // 11x11 frames
        for (int j = 0; j < 15; j++) body[j] = 8'hFF;
        body[15] = 8'hFE;
        run_good(11, 11, 0, 1'b1);
        check("11x11 bit120 zero", 128'(solution[120]), 128'(0));
        body[15] = 8'h01;
        run_good(11, 11, 0, 1'b1);
        check("11x11 all ones", {7'd0, solution}, {7'd0, {121{1'b1}}});

        // Bad headers
        run_bad_m(8'h00);
        run_bad_m(8'h0C);
        run_bad_n(5, 8'h0C);
        @(negedge clk_50mhz);

        // Timeout then good frame
        run_timeout(2, 3, 0);
        body[0] = 8'h15;
        run_good(2, 3, 0, 1'b1);

        // Back-to-back frames, no gaps
        body[0] = 8'h2D;
        run_good(2, 3, 0, 1'b0);
        body[0] = 8'h12;
        run_good(2, 3, 0, 1'b1);
        check("b2b low bits", 128'(solution[5:0]), 128'(6'b010010));

        // Reset mid-body
        send_byte(8'h0B, 0);
        send_byte(8'h0B, 0);
        for (int j = 0; j < 5; j++) send_byte(8'hA5, 0);
        rst = 1'b1;
        @(negedge clk_50mhz);
        rst = 1'b0;
        exp_sol = '0;
        exp_m   = 0;
        exp_n   = 0;
        expect_flags("mid reset", 1'b0, 1'b0, 1'b0);
        check_outputs("mid reset");
        body[0] = 8'h2D;
        run_good(2, 3, 1, 1'b1);

        // Longest legal inter-byte gap is accepted
        for (int j = 0; j < 16; j++) body[j] = 8'($urandom_range(0, 255));
        run_good(3, 4, TO - 1, 1'b1);

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            mm   = $urandom_range(1, 11);
            nn   = $urandom_range(1, 11);
            for (int j = 0; j < 16; j++) body[j] = 8'($urandom_range(0, 255));
            case (kind)
                0: run_bad_m(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(12, 255)));
                1: run_bad_n(mm, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(12, 255)));
                2: run_timeout(mm, nn, $urandom_range(0, (mm * nn + 7) / 8 - 1));
                default: run_good(mm, nn, 3, $urandom_range(0, 1) == 1);
            endcase
        end
        @(negedge clk_50mhz);
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
